// File: rtl/pl_ex_mem_stage_if.sv
// EX/MEM boundary bundle of the RV32I pipeline.
// Execute-side inputs plus redirect, MEM register and statistics outputs.
interface pl_ex_mem_stage_if #(
    parameter int W = 32
);
    logic         ValidE;
    logic [W-1:0] ALUResult;
    logic         ZeroFlag;
    logic [W-1:0] WriteDataE;
    logic [4:0]   RdE;
    logic         RegWriteE;
    logic         MemWriteE;
    logic [1:0]   ResultSrcE;
    logic [W-1:0] PCPlus4E;
    logic [W-1:0] PCTargetE;
    logic         BranchE;
    logic         BranchInvE;
    logic         JumpE;
    logic         JalrE;
    logic         StallM;

    logic         PCSrcE;
    logic [W-1:0] PCRedirectE;
    logic         FlushFE;
    logic         ValidM;
    logic         RegWriteM;
    logic         MemWriteM;
    logic [W-1:0] ALUResultM;
    logic [W-1:0] WriteDataM;
    logic [W-1:0] PCPlus4M;
    logic [4:0]   RdM;
    logic [1:0]   ResultSrcM;
    logic [31:0]  BranchCount;
    logic [31:0]  TakenCount;

    modport master (
        output ValidE, ALUResult, ZeroFlag, WriteDataE, RdE,
        output RegWriteE, MemWriteE, ResultSrcE,
        output PCPlus4E, PCTargetE,
        output BranchE, BranchInvE, JumpE, JalrE, StallM,
        input  PCSrcE, PCRedirectE, FlushFE,
        input  ValidM, RegWriteM, MemWriteM,
        input  ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM,
        input  BranchCount, TakenCount
    );

    modport slave (
        input  ValidE, ALUResult, ZeroFlag, WriteDataE, RdE,
        input  RegWriteE, MemWriteE, ResultSrcE,
        input  PCPlus4E, PCTargetE,
        input  BranchE, BranchInvE, JumpE, JalrE, StallM,
        output PCSrcE, PCRedirectE, FlushFE,
        output ValidM, RegWriteM, MemWriteM,
        output ALUResultM, WriteDataM, PCPlus4M, RdM, ResultSrcM,
        output BranchCount, TakenCount
    );
endinterface

// File: rtl/pl_ex_mem_stage.sv
// Execute-to-memory stage: branch resolution, PC redirect,
// EX/MEM pipeline register and wrap-around branch statistics.
module pl_ex_mem_stage #(
    parameter int W = 32
) (
    input logic          clk,
    input logic          rst,
    pl_ex_mem_stage_if.slave bus
);
    logic        cond;
    logic        fire;
    logic        taken;
    logic        ctl;
    logic [31:0] branch_q;
    logic [31:0] taken_q;

    // Branch resolution and redirect, combinational in the EX cycle
    always_comb begin
        cond  = bus.ZeroFlag ^ bus.BranchInvE;
        fire  = bus.ValidE & ~bus.StallM;
        ctl   = bus.BranchE | bus.JumpE;
        taken = fire & (bus.JumpE | (bus.BranchE & cond));
        bus.PCSrcE  = taken;
        bus.FlushFE = taken;
        if (bus.JalrE) begin
            bus.PCRedirectE = {bus.ALUResult[W-1:1], 1'b0};
        end else begin
            bus.PCRedirectE = bus.PCTargetE;
        end
    end

    // EX/MEM register: reset clears, stall holds, otherwise load
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ValidM     <= 1'b0;
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
            bus.RdM        <= '0;
            bus.ResultSrcM <= '0;
        end else if (!bus.StallM) begin
            bus.ValidM     <= bus.ValidE;
            bus.RegWriteM  <= bus.RegWriteE & bus.ValidE;
            bus.MemWriteM  <= bus.MemWriteE & bus.ValidE;
            bus.ALUResultM <= bus.ALUResult;
            bus.WriteDataM <= bus.WriteDataE;
            bus.PCPlus4M   <= bus.PCPlus4E;
            bus.RdM        <= bus.RdE;
            bus.ResultSrcM <= bus.ResultSrcE;
        end
    end

    // Branch statistics, free-running and wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_q <= '0;
            taken_q  <= '0;
        end else begin
            if (fire & ctl) begin
                branch_q <= branch_q + 32'd1;
            end
            if (taken) begin
                taken_q <= taken_q + 32'd1;
            end
        end
    end

    assign bus.BranchCount = branch_q;
    assign bus.TakenCount  = taken_q;
endmodule

// File: tb/tb_pl_ex_mem_stage.sv
// Directed scoreboard bench for the EX/MEM stage.
// Expected MEM contents are queued at drive time and popped after the edge.
module tb_pl_ex_mem_stage;
    localparam int W = 32;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  rs;
    } m_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    m_t   sb[$];
    m_t   cur_m;
    m_t   got_m;
    logic [31:0] exp_bc;
    logic [31:0] exp_tc;

    pl_ex_mem_stage_if #(.W(W)) b ();

    pl_ex_mem_stage #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_e();
        b.ValidE     = 1'b0;
        b.ALUResult  = '0;
        b.ZeroFlag   = 1'b0;
        b.WriteDataE = '0;
        b.RdE        = '0;
        b.RegWriteE  = 1'b0;
        b.MemWriteE  = 1'b0;
        b.ResultSrcE = '0;
        b.PCPlus4E   = '0;
        b.PCTargetE  = '0;
        b.BranchE    = 1'b0;
        b.BranchInvE = 1'b0;
        b.JumpE      = 1'b0;
        b.JalrE      = 1'b0;
        b.StallM     = 1'b0;
    endtask

    // Check comb outputs, queue the expected MEM state, clock, compare.
    task automatic step(input string tag, input logic exp_src,
                        input logic [31:0] exp_tgt);
        m_t nxt;
        #1;
        chk({tag, ".pcsrc"}, 128'(b.PCSrcE), 128'(exp_src));
        chk({tag, ".flush"}, 128'(b.FlushFE), 128'(exp_src));
        chk({tag, ".redir"}, 128'(b.PCRedirectE), 128'(exp_tgt));
        if (rst) begin
            sb.delete();
            sb.push_back('0);
            exp_bc = '0;
            exp_tc = '0;
        end else begin
            if (b.StallM) begin
                sb.push_back(cur_m);
            end else begin
                nxt.v   = b.ValidE;
                nxt.rw  = b.RegWriteE & b.ValidE;
                nxt.mw  = b.MemWriteE & b.ValidE;
                nxt.alu = b.ALUResult;
                nxt.wd  = b.WriteDataE;
                nxt.pc4 = b.PCPlus4E;
                nxt.rd  = b.RdE;
                nxt.rs  = b.ResultSrcE;
                sb.push_back(nxt);
                if (b.ValidE && (b.BranchE || b.JumpE)) exp_bc++;
            end
            if (exp_src) exp_tc++;
        end
        @(posedge clk);
        #1;
        cur_m = sb.pop_front();
        got_m = {b.ValidM, b.RegWriteM, b.MemWriteM, b.ALUResultM,
                 b.WriteDataM, b.PCPlus4M, b.RdM, b.ResultSrcM};
        chk({tag, ".mreg"}, 128'(got_m), 128'(cur_m));
        chk({tag, ".bcnt"}, 128'(b.BranchCount), 128'(exp_bc));
        chk({tag, ".tcnt"}, 128'(b.TakenCount), 128'(exp_tc));
        clr_e();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_bc   = '0;
        exp_tc   = '0;
        cur_m    = '0;
        clr_e();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 1'b0, 32'h0);
        rst = 1'b0;

        // BEQ taken
        b.ValidE = 1; b.BranchE = 1; b.ZeroFlag = 1;
        b.PCTargetE = 32'h100; b.PCPlus4E = 32'h10;
        step("beq_taken", 1'b1, 32'h100);

        // BLT not taken: SLT gave 0
        b.ValidE = 1; b.BranchE = 1; b.BranchInvE = 1;
        b.ZeroFlag = 1; b.ALUResult = 0; b.PCTargetE = 32'h200;
        step("blt_nt", 1'b0, 32'h200);

        // BGE taken: SLT gave 0
        b.ValidE = 1; b.BranchE = 1; b.ZeroFlag = 1;
        b.PCTargetE = 32'h240;
        step("bge_t", 1'b1, 32'h240);

        // BGEU not taken: SLTU gave 1
        b.ValidE = 1; b.BranchE = 1; b.ALUResult = 1;
        b.PCTargetE = 32'h280;
        step("bgeu_nt", 1'b0, 32'h280);

        // JALR, bit 0 cleared from ALU target
        b.ValidE = 1; b.JumpE = 1; b.JalrE = 1; b.RegWriteE = 1;
        b.ALUResult = 32'h2003; b.PCPlus4E = 32'h44;
        b.PCTargetE = 32'h999; b.RdE = 5'd1; b.ResultSrcE = 2'd2;
        step("jalr", 1'b1, 32'h2002);

        // JAL uses PC+imm even with odd ALU result
        b.ValidE = 1; b.JumpE = 1; b.RegWriteE = 1;
        b.ALUResult = 32'h1235; b.PCTargetE = 32'h80;
        b.PCPlus4E = 32'h60; b.RdE = 5'd1; b.ResultSrcE = 2'd2;
        step("jal", 1'b1, 32'h80);

        // Store
        b.ValidE = 1; b.MemWriteE = 1; b.ALUResult = 32'h400;
        b.WriteDataE = 32'hDEAD_BEEF; b.PCPlus4E = 32'h64;
        step("store", 1'b0, 32'h0);

        // Load M with ALUResultM=0xAA
        b.ValidE = 1; b.RegWriteE = 1; b.ALUResult = 32'hAA;
        b.RdE = 5'd5; b.PCPlus4E = 32'h68;
        step("load_aa", 1'b0, 32'h0);

        // Taken BNE held by three stall cycles, then released
        for (int i = 0; i < 4; i++) begin
            b.ValidE = 1; b.BranchE = 1; b.BranchInvE = 1;
            b.ZeroFlag = 0; b.ALUResult = 32'h5;
            b.PCTargetE = 32'h300; b.PCPlus4E = 32'h6C;
            b.StallM = (i < 3);
            if (i < 3) step("bne_stall", 1'b0, 32'h300);
            else       step("bne_go", 1'b1, 32'h300);
        end
        step("after_go", 1'b0, 32'h0);

        // Bubble with jump and write enables set
        b.ValidE = 0; b.RegWriteE = 1; b.MemWriteE = 1; b.JumpE = 1;
        b.ALUResult = 32'h77; b.PCTargetE = 32'h500;
        step("bubble", 1'b0, 32'h500);

        // Wrap TakenCount
        force dut.taken_q = 32'hFFFF_FFFF;
        #1;
        release dut.taken_q;
        exp_tc = 32'hFFFF_FFFF;
        b.ValidE = 1; b.BranchE = 1; b.ZeroFlag = 1;
        b.PCTargetE = 32'h600;
        step("wrap", 1'b1, 32'h600);

        // Load something, then reset under stall with a taken branch in E
        b.ValidE = 1; b.RegWriteE = 1; b.ALUResult = 32'h1234;
        b.RdE = 5'd9; b.PCPlus4E = 32'h70;
        step("preload", 1'b0, 32'h0);
        rst = 1'b1;
        b.ValidE = 1; b.BranchE = 1; b.ZeroFlag = 1; b.StallM = 1;
        b.PCTargetE = 32'h700;
        step("rst_stall", 1'b0, 32'h700);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
